// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm scheduler: FSM state encoding, the BCD
// time record, slot/timing constants and small index helpers.
// ---------------------------------------------------------------------------
package alarm_pkg;

  localparam int NUM_SLOTS  = 4;
  localparam int RING_MIN   = 10;  // minutes an alarm sounds before giving up
  localparam int SNOOZE_MIN = 5;   // minutes of silence per snooze
  localparam int MAX_SNOOZE = 3;   // snoozes allowed per alarm event

  localparam int SLOT_W = 2;
  localparam int DUR_W  = 4;       // holds 0..RING_MIN-1
  localparam int SNZ_W  = 3;       // holds 0..SNOOZE_MIN-1
  localparam int USED_W = 2;       // holds 0..MAX_SNOOZE

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  // 13-bit BCD time HH:MM, most significant digit first.
  typedef struct packed {
    logic [1:0] hr1;
    logic [3:0] hr0;
    logic [2:0] min1;
    logic [3:0] min0;
  } bcd_time_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [SLOT_W-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
    logic [NUM_SLOTS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// ---------------------------------------------------------------------------
// alarm_slot
// One alarm slot: stored BCD time plus armed bit, and an equality comparator
// against the current time.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : load wr_time / wr_arm into this slot
//   wr_time    : BCD time to store (not range-checked)
//   wr_arm     : armed bit to store
//   cur_time   : current BCD time
//   match      : slot is armed and its time equals cur_time
// ---------------------------------------------------------------------------
module alarm_slot
  import alarm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  bcd_time_t wr_time,
  input  logic      wr_arm,
  input  bcd_time_t cur_time,
  output logic      match
);

  bcd_time_t alarm_time;
  logic      armed;

  // NOTE: non-blocking assignments for all clocked state so every register
  // samples pre-edge values regardless of process ordering.
  // NOTE: the slot storage is reset (not left to power-up) because a reset
  // must guarantee that no stale alarm can fire afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_time <= '0;
      armed      <= 1'b0;
    end else if (wr_en) begin
      alarm_time <= wr_time;
      armed      <= wr_arm;
    end
  end

  assign match = armed && (alarm_time == cur_time);

endmodule

// File: rtl/alarm_scheduler.sv
// ---------------------------------------------------------------------------
// alarm_scheduler
// Four-slot alarm clock controller. Armed slots whose time matches the
// current time on a minute tick become pending; pending slots are served one
// at a time, lowest index first, through IDLE -> RINGING <-> SNOOZE.
//   clk, rst            : clock, synchronous active-high reset
//   tick                : one-cycle pulse each minute
//   cur_hr1..cur_min0   : current BCD time (already updated in the tick cycle)
//   wr_en, wr_slot      : slot write strobe and target slot
//   wr_hr1..wr_min0     : BCD alarm time to store
//   wr_arm              : armed bit to store
//   snooze, dismiss     : user pulses
//   led_on              : alarm sounding
//   active_slot         : slot being served, 0 when idle
//   busy                : not IDLE
// ---------------------------------------------------------------------------
module alarm_scheduler
  import alarm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [1:0]        cur_hr1,
  input  logic [3:0]        cur_hr0,
  input  logic [2:0]        cur_min1,
  input  logic [3:0]        cur_min0,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [1:0]        wr_hr1,
  input  logic [3:0]        wr_hr0,
  input  logic [2:0]        wr_min1,
  input  logic [3:0]        wr_min0,
  input  logic              wr_arm,
  input  logic              snooze,
  input  logic              dismiss,
  output logic              led_on,
  output logic [SLOT_W-1:0] active_slot,
  output logic              busy
);

  bcd_time_t cur_time;
  bcd_time_t wr_time;
  logic [NUM_SLOTS-1:0] match;

  assign cur_time = {cur_hr1, cur_hr0, cur_min1, cur_min0};
  assign wr_time  = {wr_hr1, wr_hr0, wr_min1, wr_min0};

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    alarm_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en && (wr_slot == SLOT_W'(g))),
      .wr_time  (wr_time),
      .wr_arm   (wr_arm),
      .cur_time (cur_time),
      .match    (match[g])
    );
  end

  state_t               state, state_next;
  logic [SLOT_W-1:0]    act_slot, act_slot_next;
  logic [NUM_SLOTS-1:0] pending, pending_next;
  logic [DUR_W-1:0]     dur_cnt, dur_cnt_next;
  logic [SNZ_W-1:0]     snz_cnt, snz_cnt_next;
  logic [USED_W-1:0]    snz_used, snz_used_next;

  logic [NUM_SLOTS-1:0] serve_clr;
  logic [NUM_SLOTS-1:0] wr_clr;
  logic                 wr_hits_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      act_slot <= '0;
      pending  <= '0;
      dur_cnt  <= '0;
      snz_cnt  <= '0;
      snz_used <= '0;
    end else begin
      state    <= state_next;
      act_slot <= act_slot_next;
      pending  <= pending_next;
      dur_cnt  <= dur_cnt_next;
      snz_cnt  <= snz_cnt_next;
      snz_used <= snz_used_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_next    = state;
    act_slot_next = act_slot;
    dur_cnt_next  = dur_cnt;
    snz_cnt_next  = snz_cnt;
    snz_used_next = snz_used;
    serve_clr     = '0;
    wr_clr        = wr_en ? slot_onehot(wr_slot) : '0;
    // Rewriting the slot being served invalidates the event in progress.
    wr_hits_active = wr_en && (wr_slot == act_slot);

    unique case (state)
      ST_IDLE: begin
        if (|pending) begin
          state_next    = ST_RINGING;
          act_slot_next = lowest_set(pending);
          serve_clr     = slot_onehot(act_slot_next);
          dur_cnt_next  = '0;
          snz_used_next = '0;
        end
      end

      ST_RINGING: begin
        // Priority: slot rewrite / dismiss, then snooze, then tick.
        if (wr_hits_active || dismiss) begin
          state_next = ST_IDLE;
        end else if (snooze) begin
          if (snz_used < USED_W'(MAX_SNOOZE)) begin
            state_next    = ST_SNOOZE;
            snz_cnt_next  = '0;
            snz_used_next = snz_used + 1'b1;
          end else begin
            state_next = ST_IDLE;  // snooze budget spent: acts as dismiss
          end
        end else if (tick) begin
          if (dur_cnt == DUR_W'(RING_MIN - 1)) state_next = ST_IDLE;
          else dur_cnt_next = dur_cnt + 1'b1;
        end
      end

      ST_SNOOZE: begin
        if (wr_hits_active || dismiss) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (snz_cnt == SNZ_W'(SNOOZE_MIN - 1)) begin
            state_next   = ST_RINGING;
            dur_cnt_next = '0;
          end else begin
            snz_cnt_next = snz_cnt + 1'b1;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // New matches are captured in every state; a write to a slot wins over a
    // match on that slot in the same cycle.
    pending_next = (pending | (tick ? match : '0)) & ~serve_clr & ~wr_clr;
  end

  assign led_on      = (state == ST_RINGING);
  assign busy        = (state != ST_IDLE);
  assign active_slot = busy ? act_slot : '0;

endmodule

// File: tb/tb_alarm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alarm_scheduler
// Directed self-checking bench for alarm_scheduler. Inputs are driven 1 ns
// after each rising edge and outputs are checked at the same point, so each
// check sees the state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_alarm_scheduler;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [1:0] cur_hr1;
  logic [3:0] cur_hr0;
  logic [2:0] cur_min1;
  logic [3:0] cur_min0;
  logic       wr_en;
  logic [1:0] wr_slot;
  logic [1:0] wr_hr1;
  logic [3:0] wr_hr0;
  logic [2:0] wr_min1;
  logic [3:0] wr_min0;
  logic       wr_arm;
  logic       snooze;
  logic       dismiss;
  logic       led_on;
  logic [1:0] active_slot;
  logic       busy;

  int total = 0;
  int bad   = 0;

  alarm_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .cur_hr1     (cur_hr1),
    .cur_hr0     (cur_hr0),
    .cur_min1    (cur_min1),
    .cur_min0    (cur_min0),
    .wr_en       (wr_en),
    .wr_slot     (wr_slot),
    .wr_hr1      (wr_hr1),
    .wr_hr0      (wr_hr0),
    .wr_min1     (wr_min1),
    .wr_min0     (wr_min0),
    .wr_arm      (wr_arm),
    .snooze      (snooze),
    .dismiss     (dismiss),
    .led_on      (led_on),
    .active_slot (active_slot),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int led, input int bsy, input int slot);
    check({tag, ".led_on"}, int'(led_on), led);
    check({tag, ".busy"}, int'(busy), bsy);
    check({tag, ".active_slot"}, int'(active_slot), slot);
  endtask

  task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0,
                         input logic [2:0] m1, input logic [3:0] m0);
    cur_hr1  = h1;
    cur_hr0  = h0;
    cur_min1 = m1;
    cur_min0 = m0;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  task automatic write_slot(input logic [1:0] s, input logic [1:0] h1, input logic [3:0] h0,
                            input logic [2:0] m1, input logic [3:0] m0, input logic arm);
    wr_en   = 1'b1;
    wr_slot = s;
    wr_hr1  = h1;
    wr_hr0  = h0;
    wr_min1 = m1;
    wr_min0 = m0;
    wr_arm  = arm;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
  endtask

  // Slot 0 holds 07:30 armed; match it, then move the clock off the match.
  task automatic ring_slot0(input string tag);
    set_cur(2'd0, 4'd7, 3'd3, 4'd0);
    tick_once();
    set_cur(2'd0, 4'd7, 3'd3, 4'd1);
    step();
    expect_out(tag, 1, 1, 0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_slot = '0; wr_arm = 1'b0;
    wr_hr1 = '0; wr_hr0 = '0; wr_min1 = '0; wr_min0 = '0;
    snooze = 1'b0; dismiss = 1'b0;
    set_cur(2'd0, 4'd0, 3'd0, 4'd0);
    step();
    step();
    rst = 1'b0;
    expect_out("reset", 0, 0, 0);

    // Basic ring on slot 0 at 07:30, one-edge latency, ten-minute timeout.
    write_slot(2'd0, 2'd0, 4'd7, 3'd3, 4'd0, 1'b1);
    set_cur(2'd0, 4'd7, 3'd3, 4'd0);
    tick_once();
    expect_out("latency_tick_edge", 0, 0, 0);
    set_cur(2'd0, 4'd7, 3'd3, 4'd1);
    step();
    expect_out("ring0_start", 1, 1, 0);
    ticks(9);
    expect_out("ring0_tick9", 1, 1, 0);
    tick_once();
    expect_out("ring0_tick10", 0, 0, 0);

    // Two slots matching the same minute are served in index order.
    write_slot(2'd1, 2'd0, 4'd6, 3'd0, 4'd0, 1'b1);
    write_slot(2'd2, 2'd0, 4'd6, 3'd0, 4'd0, 1'b1);
    set_cur(2'd0, 4'd6, 3'd0, 4'd0);
    tick_once();
    set_cur(2'd0, 4'd6, 3'd0, 4'd1);
    step();
    expect_out("dual_slot1", 1, 1, 1);
    ticks(9);
    check("dual_slot1_tick9.led_on", int'(led_on), 1);
    tick_once();
    expect_out("dual_gap_idle", 0, 0, 0);
    step();
    expect_out("dual_slot2", 1, 1, 2);
    pulse_dismiss();
    expect_out("dual_dismiss", 0, 0, 0);

    // Three snoozes of five minutes each, fourth snooze acts as dismiss.
    ring_slot0("snz_ring");
    for (int s = 0; s < 3; s++) begin
      pulse_snooze();
      expect_out($sformatf("snz%0d_enter", s), 0, 1, 0);
      ticks(4);
      check($sformatf("snz%0d_tick4.led_on", s), int'(led_on), 0);
      tick_once();
      expect_out($sformatf("snz%0d_tick5", s), 1, 1, 0);
    end
    pulse_snooze();
    expect_out("snz_fourth", 0, 0, 0);

    // User pulses while idle do nothing.
    snooze = 1'b1;
    dismiss = 1'b1;
    step();
    snooze = 1'b0;
    dismiss = 1'b0;
    expect_out("idle_pulses", 0, 0, 0);

    // Snooze + dismiss + matching tick together: idle, and the match queued.
    ring_slot0("combo_ring");
    write_slot(2'd3, 2'd0, 4'd8, 3'd0, 4'd0, 1'b1);
    expect_out("combo_other_write", 1, 1, 0);
    set_cur(2'd0, 4'd8, 3'd0, 4'd0);
    snooze = 1'b1;
    dismiss = 1'b1;
    tick = 1'b1;
    step();
    snooze = 1'b0;
    dismiss = 1'b0;
    tick = 1'b0;
    expect_out("combo_idle", 0, 0, 0);
    set_cur(2'd0, 4'd8, 3'd0, 4'd1);
    step();
    expect_out("combo_slot3", 1, 1, 3);
    pulse_dismiss();
    expect_out("combo_dismiss", 0, 0, 0);

    // Disarm-by-write before the matching tick.
    write_slot(2'd3, 2'd1, 4'd2, 3'd0, 4'd0, 1'b1);
    write_slot(2'd3, 2'd1, 4'd2, 3'd0, 4'd0, 1'b0);
    set_cur(2'd1, 4'd2, 3'd0, 4'd0);
    tick_once();
    step();
    expect_out("disarmed_slot3", 0, 0, 0);

    // Rewriting the active slot mid-ring aborts to idle and stays there.
    ring_slot0("wr_active_ring");
    ticks(3);
    check("wr_active_tick3.led_on", int'(led_on), 1);
    write_slot(2'd0, 2'd0, 4'd7, 3'd3, 4'd0, 1'b1);
    expect_out("wr_active_idle", 0, 0, 0);
    step();
    expect_out("wr_active_stay", 0, 0, 0);

    // Reset during snooze clears everything, including stored alarms.
    ring_slot0("rst_ring");
    pulse_snooze();
    expect_out("rst_snooze", 0, 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("rst_mid_snooze", 0, 0, 0);
    set_cur(2'd0, 4'd7, 3'd3, 4'd0);
    tick_once();
    step();
    step();
    expect_out("rst_no_ring_0730", 0, 0, 0);
    set_cur(2'd0, 4'd0, 3'd0, 4'd0);
    tick_once();
    step();
    expect_out("rst_no_ring_0000", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
